// File: rtl/acl_spi_ctrl.sv
// SPI master that powers up an ADXL362-style accelerometer, then reads X/Y/Z every SAMPLE_PERIOD.
// state      | meaning
// ST_STARTUP | CSN high, counting power-up delay after reset
// ST_INIT    | write POWER_CTL frame (0x0A 0x2D 0x02)
// ST_WAIT    | CSN high: minimum gap, then wait for the next sample slot
// ST_READ    | read frame (0x0B 0x08, then 24 clocks capturing X, Y, Z)
module acl_spi_ctrl #(
  parameter int CLK_DIV       = 25,
  parameter int STARTUP       = 600_000,
  parameter int SAMPLE_PERIOD = 1_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       ACL_MISO,
  output logic       ACL_MOSI,
  output logic       ACL_SCLK,
  output logic       ACL_CSN,
  output logic [7:0] acl_x,
  output logic [7:0] acl_y,
  output logic [7:0] acl_z,
  output logic       sample_valid,
  output logic       init_done
);

  localparam int HI_CYC = CLK_DIV / 2;
  localparam int LO_CYC = CLK_DIV - HI_CYC;
  localparam int TW     = $clog2(CLK_DIV + 1);
  localparam int SW     = (STARTUP > 1) ? $clog2(STARTUP) : 1;
  localparam int PW     = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [TW-1:0] T_GUARD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_LO    = TW'(LO_CYC - 1);
  localparam logic [TW-1:0] T_HI    = TW'(HI_CYC - 1);
  localparam logic [SW-1:0] SU_LAST = SW'(STARTUP - 1);
  localparam logic [PW-1:0] P_LOAD  = PW'(SAMPLE_PERIOD - 1);

  localparam logic [39:0] TX_INIT = {24'h0A2D02, 16'h0000};
  localparam logic [39:0] TX_READ = {16'h0B08, 24'h000000};

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_INIT    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_READ    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_LEAD = 2'd0,
    PH_LO   = 2'd1,
    PH_HI   = 2'd2,
    PH_TAIL = 2'd3
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] gap_q, gap_d;
  logic [SW-1:0] su_q, su_d;
  logic [PW-1:0] per_q, per_d;
  logic [5:0]    bits_q, bits_d;
  logic [39:0]   tx_q, tx_d;
  logic [23:0]   rx_q, rx_d;
  logic          csn_q, csn_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [7:0]    z_q, z_d;
  logic          sv_q, sv_d;
  logic          init_q, init_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    su_d    = su_q;
    per_d   = per_q;
    bits_d  = bits_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    sv_d    = 1'b0;
    init_d  = init_q;

    // Sample-slot timer runs freely and saturates at zero until the next read reloads it.
    if (per_q != '0) per_d = per_q - 1'b1;

    case (state_q)
      ST_STARTUP: begin
        if (su_q == SU_LAST) begin
          state_d = ST_INIT;
          phase_d = PH_LEAD;
          tmr_d   = T_GUARD;
          bits_d  = 6'd24;
          tx_d    = TX_INIT;
          csn_d   = 1'b0;
        end else begin
          su_d = su_q + 1'b1;
        end
      end

      ST_INIT, ST_READ: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          case (phase_q)
            PH_LEAD: begin
              phase_d = PH_LO;
              tmr_d   = T_LO;
              mosi_d  = tx_q[39];
              tx_d    = {tx_q[38:0], 1'b0};
            end
            PH_LO: begin
              phase_d = PH_HI;
              tmr_d   = T_HI;
              sclk_d  = 1'b1;
              rx_d    = {rx_q[22:0], ACL_MISO};
            end
            PH_HI: begin
              sclk_d = 1'b0;
              if (bits_q == 6'd1) begin
                phase_d = PH_TAIL;
                tmr_d   = T_GUARD;
                mosi_d  = 1'b0;
              end else begin
                bits_d  = bits_q - 1'b1;
                phase_d = PH_LO;
                tmr_d   = T_LO;
                mosi_d  = tx_q[39];
                tx_d    = {tx_q[38:0], 1'b0};
              end
            end
            PH_TAIL: begin
              csn_d   = 1'b1;
              state_d = ST_WAIT;
              gap_d   = T_GUARD;
              if (state_q == ST_INIT) begin
                init_d = 1'b1;
              end else begin
                // Only the last 24 captured bits survive the shift: X, Y, Z in order.
                x_d  = rx_q[23:16];
                y_d  = rx_q[15:8];
                z_d  = rx_q[7:0];
                sv_d = 1'b1;
              end
            end
            default: phase_d = PH_LEAD;
          endcase
        end
      end

      ST_WAIT: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (per_q == '0) begin
          state_d = ST_READ;
          phase_d = PH_LEAD;
          tmr_d   = T_GUARD;
          bits_d  = 6'd40;
          tx_d    = TX_READ;
          csn_d   = 1'b0;
          per_d   = P_LOAD;
        end
      end

      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q <= ST_STARTUP;
      phase_q <= PH_LEAD;
      tmr_q   <= '0;
      gap_q   <= '0;
      su_q    <= '0;
      per_q   <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sv_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      su_q    <= su_d;
      per_q   <= per_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sv_q    <= sv_d;
      init_q  <= init_d;
    end
  end

  assign ACL_CSN      = csn_q;
  assign ACL_SCLK     = sclk_q;
  assign ACL_MOSI     = mosi_q;
  assign acl_x        = x_q;
  assign acl_y        = y_q;
  assign acl_z        = z_q;
  assign sample_valid = sv_q;
  assign init_done    = init_q;

endmodule

// File: doc/acl_spi_ctrl.md
ACL_SPI_CTRL -- requirements
Module: acl_spi_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter CLK_DIV, 25, CLK100MHZ cycles per SCLK period (4 MHz); legal range >= 4.
REQ-003 Parameter STARTUP, 600_000, idle cycles after reset before the init frame.
REQ-004 Parameter SAMPLE_PERIOD, 1_000_000, cycles between read-frame starts (100 Hz).
REQ-005 Port CLK100MHZ  in  1  system clock, 100 MHz.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port ACL_MISO  in  1  accelerometer serial data out.
REQ-008 Port ACL_MOSI  out  1  serial data to accelerometer.
REQ-009 Port ACL_SCLK  out  1  SPI clock, mode 0.
REQ-010 Port ACL_CSN  out  1  chip select, active low.
REQ-011 Ports acl_x, acl_y, acl_z  out  8 each  latest X/Y/Z samples, raw two's complement.
REQ-012 Port sample_valid  out  1  one-cycle pulse on each acl_x/y/z update.
REQ-013 Port init_done  out  1  high after the init frame completes; stays high until reset.

Function
REQ-014 SCLK SHALL be generated internally from CLK100MHZ: low for CLK_DIV-CLK_DIV/2 cycles (13), then high for CLK_DIV/2 cycles (12), per bit; SCLK SHALL idle low.
REQ-015 MOSI SHALL change only at the start of a bit's low phase, MSB first; MISO SHALL be sampled on the CLK100MHZ edge at which SCLK goes 0->1.
REQ-016 Frame framing: CSN falls, CLK_DIV guard cycles, bits, CLK_DIV guard cycles with SCLK low, CSN rises; CSN SHALL then stay high for at least CLK_DIV cycles.
REQ-017 States: STARTUP -> INIT_FRAME -> WAIT -> READ_FRAME -> WAIT ...; no other transitions except reset.
REQ-018 STARTUP SHALL last exactly STARTUP cycles after reset deassertion, with CSN high.
REQ-019 INIT_FRAME SHALL send 24 bits: 0x0A, 0x2D, 0x02 (write POWER_CTL = measure); MISO ignored.
REQ-020 init_done SHALL rise in the cycle CSN rises at the end of INIT_FRAME.
REQ-021 READ_FRAME SHALL send 0x0B, 0x08 (16 bits), then 24 clocks with MOSI held 0, capturing three MISO bytes as X, Y, Z.
REQ-022 acl_x, acl_y, acl_z SHALL update together, with sample_valid high for exactly one cycle, in the cycle CSN rises at the end of READ_FRAME; there SHALL be no partial updates.
REQ-023 The first READ_FRAME CSN fall SHALL occur after the init CSN-high minimum; subsequent READ_FRAME CSN falls SHALL be exactly SAMPLE_PERIOD cycles apart.
REQ-024 If SAMPLE_PERIOD is shorter than frame length plus the CSN-high minimum, the next read SHALL start immediately after the CSN-high minimum, without overlap.
REQ-025 Each frame SHALL output exactly 24 (init) or 40 (read) SCLK rising edges, with no extra edges while CSN is high.

Reset
REQ-026 While reset is high: ACL_CSN=1, ACL_SCLK=0, ACL_MOSI=0, acl_x/y/z=0x00, sample_valid=0, init_done=0, state=STARTUP, all counters 0.
REQ-027 Reset asserted mid-frame SHALL force the REQ-026 values asynchronously, without waiting for the clock; after release, the full STARTUP and init sequence SHALL be repeated.

Verification (CLK_DIV=25, STARTUP=10, SAMPLE_PERIOD=2000, MISO slave model)
REQ-028 Reset release -> CSN high for 10 cycles, then init frame decodes as 0x0A 0x2D 0x02 with 24 SCLK rises; init_done=1 at CSN rise.
REQ-029 Model returns 0x12, 0x34, 0x56 -> MOSI decodes 0x0B 0x08; acl_x=0x12, acl_y=0x34, acl_z=0x56 with a single sample_valid pulse at CSN rise.
REQ-030 SCLK measurement -> period 25 cycles, high 12 cycles; 40 rising edges per read frame; no MOSI change while SCLK high.
REQ-031 Three consecutive read frames -> CSN falling edges exactly 2000 cycles apart; sample_valid count = 3.
REQ-032 Reset asserted at bit 20 of a read frame -> CSN=1, SCLK=0 before the next clock edge; outputs 0x00; the previous samples are discarded and the init frame is repeated.
REQ-033 Model returns 0xFF, 0x80, 0x7F -> outputs equal those raw bytes, with no sign manipulation.
